// File: rtl/spi_bus_pkg.sv
// Shared encodings for the SPI-to-register-bus bridge: FSM states,
// command byte fields and status byte layout.
package spi_bus_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR_HI  = 3'd1;
  localparam logic [2:0] ST_WR_LO  = 3'd2;
  localparam logic [2:0] ST_RD_PAD = 3'd3;
  localparam logic [2:0] ST_RD_HI  = 3'd4;
  localparam logic [2:0] ST_RD_LO  = 3'd5;

  localparam int unsigned CMD_RD    = 7;
  localparam int unsigned CMD_BURST = 6;
  localparam int unsigned CMD_CLR   = 5;

  localparam int unsigned STAT_OVR = 3;
  localparam int unsigned STAT_TMO = 2;
  localparam int unsigned STAT_REQ = 1;

  function automatic logic [7:0] status_byte(input logic [3:0] id, input logic ovr,
                                             input logic tmo, input logic req);
    status_byte = {id, 4'b0000};
    status_byte[STAT_OVR] = ovr;
    status_byte[STAT_TMO] = tmo;
    status_byte[STAT_REQ] = req;
  endfunction

endpackage

// File: rtl/spi_bus_req.sv
// Register-bus request engine: req/ack handshake with timeout and the
// read-data holding register.
module spi_bus_req #(
  parameter int unsigned REG_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wr,
  input  logic [REG_W-1:0] reg_num,
  input  logic [15:0]      wdata,
  input  logic             flush,
  output logic             req,
  output logic             req_wr,
  output logic [REG_W-1:0] req_reg,
  output logic [15:0]      req_data,
  input  logic             ack,
  input  logic [15:0]      rdata,
  output logic [15:0]      hold,
  output logic             rd_valid,
  output logic             timeout
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      req      <= 1'b0;
      req_wr   <= 1'b0;
      req_reg  <= '0;
      req_data <= '0;
      cnt      <= '0;
      discard  <= 1'b0;
      hold     <= '0;
      rd_valid <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (flush) rd_valid <= 1'b0;
      if (req) begin
        // A flushed request still runs to ack/timeout, but its data is dropped.
        if (flush) discard <= 1'b1;
        if (ack) begin
          req <= 1'b0;
          if (!req_wr && !discard && !flush) begin
            hold     <= rdata;
            rd_valid <= 1'b1;
          end
        end else if (cnt == LAST) begin
          req     <= 1'b0;
          timeout <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (start) begin
        req      <= 1'b1;
        req_wr   <= wr;
        req_reg  <= reg_num;
        req_data <= wdata;
        cnt      <= '0;
        discard  <= 1'b0;
        if (!wr) rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_bus_ctrl.sv
// SPI byte-target sequencer: decodes command/data bytes into register-bus
// requests and chooses the next byte shifted back to the host.
module spi_bus_ctrl
  import spi_bus_pkg::*;
#(
  parameter int unsigned REG_W       = 4,
  parameter logic [3:0]  ID_NIBBLE   = 4'hA,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             spi_cs_i,
  input  logic             rx_strobe_i,
  input  logic [7:0]       rx_byte_i,
  input  logic             tx_strobe_i,
  output logic [7:0]       tx_byte_o,
  output logic             bus_req_o,
  output logic             bus_wr_o,
  output logic [REG_W-1:0] bus_reg_o,
  output logic [15:0]      bus_data_o,
  input  logic             bus_ack_i,
  input  logic [15:0]      bus_data_i,
  output logic             busy_o
);

  logic [1:0]       cs_sync;
  logic             cs_n;
  logic [2:0]       state;
  logic [REG_W-1:0] reg_num;
  logic             burst;
  logic [7:0]       data_hi;
  logic             ovr, tmo;
  logic             rd_pend, rd_fail, lo_sel;
  logic             rd_evt, rd_start, wr_start, req_start, flush;
  logic [REG_W-1:0] req_reg;
  logic [15:0]      hold;
  logic             rd_valid, timeout;

  assign cs_n = cs_sync[1];

  always_comb begin
    rd_evt   = 1'b0;
    wr_start = 1'b0;
    req_reg  = reg_num;
    if (!cs_n && rx_strobe_i) begin
      case (state)
        ST_IDLE: begin
          rd_evt  = rx_byte_i[CMD_RD];
          req_reg = rx_byte_i[REG_W-1:0];
        end
        ST_WR_LO: wr_start = !bus_req_o;
        ST_RD_LO: begin
          rd_evt  = burst;
          req_reg = reg_num + REG_W'(1);
        end
        default: ;
      endcase
    end
    // A read blocked by a stale request is remembered in rd_pend and issued once req drops.
    rd_start  = !cs_n && !bus_req_o && (rd_evt || rd_pend);
    req_start = rd_start || wr_start;
    flush     = cs_n || rd_evt;
  end

  spi_bus_req #(
    .REG_W      (REG_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_req (
    .clk     (clk),
    .reset   (reset_i),
    .start   (req_start),
    .wr      (wr_start),
    .reg_num (req_reg),
    .wdata   ({data_hi, rx_byte_i}),
    .flush   (flush),
    .req     (bus_req_o),
    .req_wr  (bus_wr_o),
    .req_reg (bus_reg_o),
    .req_data(bus_data_o),
    .ack     (bus_ack_i),
    .rdata   (bus_data_i),
    .hold    (hold),
    .rd_valid(rd_valid),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cs_sync <= 2'b11;
      state   <= ST_IDLE;
      reg_num <= '0;
      burst   <= 1'b0;
      data_hi <= '0;
      ovr     <= 1'b0;
      tmo     <= 1'b0;
      rd_pend <= 1'b0;
      rd_fail <= 1'b0;
      lo_sel  <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[0], spi_cs_i};
      if (rd_start) rd_pend <= 1'b0;
      if (cs_n) begin
        state   <= ST_IDLE;
        rd_pend <= 1'b0;
      end else begin
        if (rx_strobe_i) begin
          case (state)
            ST_IDLE: begin
              reg_num <= rx_byte_i[REG_W-1:0];
              burst   <= rx_byte_i[CMD_BURST];
              if (rx_byte_i[CMD_CLR]) begin
                ovr <= 1'b0;
                tmo <= 1'b0;
              end
              if (rx_byte_i[CMD_RD]) begin
                state   <= ST_RD_PAD;
                lo_sel  <= 1'b0;
                rd_fail <= 1'b0;
                if (bus_req_o) rd_pend <= 1'b1;
              end else begin
                state <= ST_WR_HI;
              end
            end
            ST_WR_HI: begin
              data_hi <= rx_byte_i;
              state   <= ST_WR_LO;
            end
            ST_WR_LO: begin
              if (bus_req_o) ovr <= 1'b1;
              if (burst) begin
                reg_num <= reg_num + REG_W'(1);
                state   <= ST_WR_HI;
              end else begin
                state <= ST_IDLE;
              end
            end
            ST_RD_PAD: state <= ST_RD_HI;
            ST_RD_HI:  state <= ST_RD_LO;
            ST_RD_LO: begin
              if (burst) begin
                reg_num <= reg_num + REG_W'(1);
                state   <= ST_RD_PAD;
                lo_sel  <= 1'b0;
                rd_fail <= 1'b0;
                if (bus_req_o) rd_pend <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
        // The high data byte has just been loaded; no valid data means the read missed its slot.
        if (tx_strobe_i && state == ST_RD_HI && !lo_sel) begin
          lo_sel <= 1'b1;
          if (!rd_valid) begin
            rd_fail <= 1'b1;
            tmo     <= 1'b1;
          end
        end
      end
      if (timeout) tmo <= 1'b1;
    end
  end

  always_comb begin
    tx_byte_o = status_byte(ID_NIBBLE, ovr, tmo, bus_req_o);
    case (state)
      ST_RD_PAD: if (rd_valid) tx_byte_o = hold[15:8];
      ST_RD_HI: begin
        if (lo_sel) tx_byte_o = rd_fail ? 8'hFF : hold[7:0];
        else        tx_byte_o = rd_valid ? hold[15:8] : 8'hFF;
      end
      ST_RD_LO: tx_byte_o = rd_fail ? 8'hFF : hold[7:0];
      default: ;
    endcase
  end

  assign busy_o = (state != ST_IDLE) || bus_req_o;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl: SPI byte frames driven by tasks, with a
// bus responder that acks requests and logs them.
module tb_spi_bus_ctrl;

  logic        clk;
  logic        reset_i;
  logic        spi_cs_i;
  logic        rx_strobe_i;
  logic [7:0]  rx_byte_i;
  logic        tx_strobe_i;
  logic [7:0]  tx_byte_o;
  logic        bus_req_o;
  logic        bus_wr_o;
  logic [3:0]  bus_reg_o;
  logic [15:0] bus_data_o;
  logic        bus_ack_i;
  logic [15:0] bus_data_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic        ack_en    = 1'b1;
  int          ack_delay = 0;
  logic [15:0] rd_word   = 16'h0000;
  logic        seen;
  int          wait_cnt;
  int          last_len;
  int          log_n;
  logic        log_wr   [0:31];
  logic [3:0]  log_reg  [0:31];
  logic [15:0] log_data [0:31];

  spi_bus_ctrl #(
    .REG_W      (4),
    .ID_NIBBLE  (4'hA),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .spi_cs_i   (spi_cs_i),
    .rx_strobe_i(rx_strobe_i),
    .rx_byte_i  (rx_byte_i),
    .tx_strobe_i(tx_strobe_i),
    .tx_byte_o  (tx_byte_o),
    .bus_req_o  (bus_req_o),
    .bus_wr_o   (bus_wr_o),
    .bus_reg_o  (bus_reg_o),
    .bus_data_o (bus_data_o),
    .bus_ack_i  (bus_ack_i),
    .bus_data_i (bus_data_i),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus responder: logs each request on its first cycle, acks after ack_delay cycles.
  initial begin
    bus_ack_i  = 1'b0;
    bus_data_i = '0;
    seen       = 1'b0;
    wait_cnt   = 0;
    last_len   = 0;
    log_n      = 0;
    forever begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      if (bus_req_o) begin
        if (!seen) begin
          seen     = 1'b1;
          wait_cnt = 0;
          if (log_n < 32) begin
            log_wr[log_n]   = bus_wr_o;
            log_reg[log_n]  = bus_reg_o;
            log_data[log_n] = bus_data_o;
          end
          log_n++;
        end
        if (ack_en && wait_cnt >= ack_delay) begin
          bus_ack_i  = 1'b1;
          bus_data_i = rd_word;
        end
        wait_cnt++;
      end else if (seen) begin
        seen     = 1'b0;
        last_len = wait_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic select();
    spi_cs_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic deselect();
    spi_cs_i = 1'b1;
    repeat (4) step();
  endtask

  // One SPI byte: target loads tx byte, shifts for a while, then delivers rx byte.
  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    miso = tx_byte_o;
    tx_strobe_i = 1'b1;
    step();
    tx_strobe_i = 1'b0;
    repeat (6) step();
    rx_strobe_i = 1'b1;
    rx_byte_i   = mosi;
    step();
    rx_strobe_i = 1'b0;
    step();
  endtask

  task automatic wait_req_low(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!bus_req_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    total++;
    if (tx_byte_o !== 8'hA0) begin bad++; $display("FAIL reset_tx got=%h want=%h", tx_byte_o, 8'hA0); end
    total++;
    if (bus_req_o !== 1'b0 || bus_wr_o !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b%b want=00", bus_req_o, bus_wr_o);
    end
    total++;
    if (bus_reg_o !== 4'h0 || bus_data_o !== 16'h0000) begin
      bad++; $display("FAIL reset_bus got=%h/%h want=0/0000", bus_reg_o, bus_data_o);
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_write();
    logic [7:0] m;
    logic       ok;
    int         n0;
    n0 = log_n;
    ack_en = 1'b1; ack_delay = 2;
    select();
    xfer(8'h03, m);
    total++;
    if (m !== 8'hA0) begin bad++; $display("FAIL wr_cmd_status got=%h want=%h", m, 8'hA0); end
    xfer(8'h12, m);
    xfer(8'h34, m);
    wait_req_low(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_req_fall got=stuck want=low"); end
    total++;
    if (log_n !== n0 + 1) begin bad++; $display("FAIL wr_count got=%0d want=%0d", log_n - n0, 1); end
    total++;
    if (log_wr[n0] !== 1'b1 || log_reg[n0] !== 4'h3 || log_data[n0] !== 16'h1234) begin
      bad++; $display("FAIL wr_txn got=%b/%h/%h want=1/3/1234", log_wr[n0], log_reg[n0], log_data[n0]);
    end
    total++;
    if (last_len !== 3) begin bad++; $display("FAIL wr_req_len got=%0d want=%0d", last_len, 3); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL wr_idle_busy got=%b want=0", busy_o); end
    deselect();
  endtask

  task automatic test_read();
    logic [7:0] m;
    ack_en = 1'b1; ack_delay = 5; rd_word = 16'hBEEF;
    select();
    xfer(8'h85, m);
    xfer(8'h00, m);
    total++;
    if (m !== 8'hA2) begin bad++; $display("FAIL rd_pad got=%h want=%h", m, 8'hA2); end
    xfer(8'h00, m);
    total++;
    if (m !== 8'hBE) begin bad++; $display("FAIL rd_hi got=%h want=%h", m, 8'hBE); end
    xfer(8'h00, m);
    total++;
    if (m !== 8'hEF) begin bad++; $display("FAIL rd_lo got=%h want=%h", m, 8'hEF); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rd_idle_busy got=%b want=0", busy_o); end
    deselect();
  endtask

  task automatic test_burst_write();
    logic [7:0] m;
    logic       ok;
    int         n0;
    n0 = log_n;
    ack_en = 1'b1; ack_delay = 1;
    select();
    xfer(8'h4F, m);
    xfer(8'h11, m);
    xfer(8'h22, m);
    xfer(8'h33, m);
    xfer(8'h44, m);
    wait_req_low(40, ok);
    total++;
    if (log_n !== n0 + 2) begin bad++; $display("FAIL bw_count got=%0d want=%0d", log_n - n0, 2); end
    total++;
    if (log_wr[n0] !== 1'b1 || log_reg[n0] !== 4'hF || log_data[n0] !== 16'h1122) begin
      bad++; $display("FAIL bw_first got=%b/%h/%h want=1/f/1122", log_wr[n0], log_reg[n0], log_data[n0]);
    end
    total++;
    if (log_wr[n0+1] !== 1'b1 || log_reg[n0+1] !== 4'h0 || log_data[n0+1] !== 16'h3344) begin
      bad++; $display("FAIL bw_wrap got=%b/%h/%h want=1/0/3344", log_wr[n0+1], log_reg[n0+1], log_data[n0+1]);
    end
    deselect();
  endtask

  task automatic test_overrun();
    logic [7:0] m;
    logic       ok;
    int         n0;
    n0 = log_n;
    ack_en = 1'b0;
    select();
    xfer(8'h4F, m);
    xfer(8'h11, m);
    xfer(8'h22, m);
    xfer(8'h33, m);
    xfer(8'h44, m);
    ack_en = 1'b1; ack_delay = 0;
    wait_req_low(40, ok);
    deselect();
    total++;
    if (log_n !== n0 + 1 || log_reg[n0] !== 4'hF || log_data[n0] !== 16'h1122) begin
      bad++; $display("FAIL ovr_log got=%0d/%h/%h want=1/f/1122", log_n - n0, log_reg[n0], log_data[n0]);
    end
    select();
    xfer(8'h20, m);
    total++;
    if (m !== 8'hA8) begin bad++; $display("FAIL ovr_status got=%h want=%h", m, 8'hA8); end
    deselect();
    select();
    xfer(8'h00, m);
    total++;
    if (m !== 8'hA0) begin bad++; $display("FAIL ovr_cleared got=%h want=%h", m, 8'hA0); end
    deselect();
  endtask

  task automatic test_timeout();
    logic [7:0] m;
    logic       ok;
    ack_en = 1'b0;
    select();
    xfer(8'h81, m);
    xfer(8'h00, m);
    total++;
    if (m !== 8'hA2) begin bad++; $display("FAIL tmo_pad got=%h want=%h", m, 8'hA2); end
    xfer(8'h00, m);
    total++;
    if (m !== 8'hFF) begin bad++; $display("FAIL tmo_hi got=%h want=%h", m, 8'hFF); end
    xfer(8'h00, m);
    total++;
    if (m !== 8'hFF) begin bad++; $display("FAIL tmo_lo got=%h want=%h", m, 8'hFF); end
    wait_req_low(100, ok);
    total++;
    if (!ok || last_len !== 64) begin bad++; $display("FAIL tmo_req_len got=%0d want=%0d", last_len, 64); end
    deselect();
    select();
    xfer(8'h20, m);
    total++;
    if (m !== 8'hA4) begin bad++; $display("FAIL tmo_status got=%h want=%h", m, 8'hA4); end
    deselect();
    select();
    xfer(8'h00, m);
    total++;
    if (m !== 8'hA0) begin bad++; $display("FAIL tmo_cleared got=%h want=%h", m, 8'hA0); end
    deselect();
    ack_en = 1'b1;
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int         n0;
    n0 = log_n;
    ack_en = 1'b1; ack_delay = 1; rd_word = 16'hC0DE;
    select();
    xfer(8'h03, m);
    xfer(8'h55, m);
    deselect();
    total++;
    if (log_n !== n0 || bus_req_o !== 1'b0) begin
      bad++; $display("FAIL abort_noreq got=%0d/%b want=0/0", log_n - n0, bus_req_o);
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
    select();
    xfer(8'h85, m);
    total++;
    if (bus_req_o !== 1'b1 || bus_wr_o !== 1'b0 || bus_reg_o !== 4'h5) begin
      bad++; $display("FAIL abort_newcmd got=%b/%b/%h want=1/0/5", bus_req_o, bus_wr_o, bus_reg_o);
    end
    xfer(8'h00, m);
    xfer(8'h00, m);
    total++;
    if (m !== 8'hC0) begin bad++; $display("FAIL abort_rd_hi got=%h want=%h", m, 8'hC0); end
    xfer(8'h00, m);
    total++;
    if (m !== 8'hDE) begin bad++; $display("FAIL abort_rd_lo got=%h want=%h", m, 8'hDE); end
    deselect();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] m;
    ack_en = 1'b0;
    select();
    xfer(8'h81, m);
    total++;
    if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b want=1", bus_req_o); end
    reset_i = 1'b1;
    step();
    total++;
    if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus_req_o); end
    total++;
    if (tx_byte_o !== 8'hA0) begin bad++; $display("FAIL rst_tx got=%h want=%h", tx_byte_o, 8'hA0); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    reset_i = 1'b0;
    deselect();
    ack_en = 1'b1;
  endtask

  initial begin
    reset_i     = 1'b1;
    spi_cs_i    = 1'b1;
    rx_strobe_i = 1'b0;
    rx_byte_i   = '0;
    tx_strobe_i = 1'b0;
    repeat (3) step();
    reset_i = 1'b0;
    step();
    test_reset();
    test_write();
    test_read();
    test_burst_write();
    test_overrun();
    test_timeout();
    test_abort();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_bus_ctrl.md
Name: spi_bus_ctrl

Overview:
Sequences the SPI byte target into a 16-bit register-bus initiator. It decodes a command byte, then data bytes, from the target's receive strobes. It issues register read/write requests with a req/ack handshake and a timeout. It supplies the byte the target shifts out next: status, read-data high byte or read-data low byte. It sits between the SPI byte target and the register-bus arbiter, so an external host can access the register file over SPI.

Parameters:
REG_W, 4, register-number width; register number = cmd[REG_W-1:0] (REG_W <= 4)
ID_NIBBLE, 4'hA, constant value of status byte bits [7:4]
ACK_TIMEOUT, 64, clk cycles to wait for bus_ack_i before abandoning a request

Ports:
clk  in  1  system clock; same clock as the SPI byte target
reset_i  in  1  synchronous, active-high reset
spi_cs_i  in  1  raw SPI chip select, active low; synchronized internally with 2 flops
rx_strobe_i  in  1  one-cycle pulse: rx_byte_i is valid
rx_byte_i  in  8  byte received from the host
tx_strobe_i  in  1  one-cycle pulse: SPI target has just loaded tx_byte_o
tx_byte_o  out  8  next byte to shift out to the host
bus_req_o  out  1  register request; held high until ack or timeout
bus_wr_o  out  1  1 = write, 0 = read; stable while bus_req_o is high
bus_reg_o  out  REG_W  register number
bus_data_o  out  16  write data
bus_ack_i  in  1  one-cycle completion pulse; read data valid in the same cycle
bus_data_i  in  16  read data
busy_o  out  1  high when state != IDLE or bus_req_o is high

Behaviour:
- Reset values: all outputs 0 except tx_byte_o = {ID_NIBBLE,4'b0000}; state IDLE; sticky flags 0; cs synchronizer = 2'b11 (deselected).
- Command byte: [7] read, [6] burst (auto-increment), [5] clear sticky flags, [4] ignored, [3:0] register number.
- Status byte: {ID_NIBBLE, ovr, tmo, bus_req_o, 1'b0}.
  - ovr (sticky): a write word completed while the previous request was still pending; the new word is dropped.
  - tmo (sticky): a request timed out, or a read was not ready in time.
- States:
  - IDLE: next rx_strobe = command; latch reg and burst. If [5], clear flags (status sent later reflects the cleared flags). Read -> RD_PAD and issue a read request immediately; write -> WR_HI.
  - WR_HI: rx byte -> data[15:8], go WR_LO.
  - WR_LO: rx byte -> data[7:0], issue a write request (or set ovr if bus_req_o is high). Burst: reg+1 (wraps mod 2^REG_W), go WR_HI. Otherwise go IDLE.
  - RD_PAD: the host clocks one turnaround byte (rx ignored), then go RD_HI.
  - RD_HI: one byte to the host, then go RD_LO.
  - RD_LO: one byte to the host. Burst: reg+1, issue the next read, go RD_PAD. Otherwise go IDLE.
- Bus handshake:
  - bus_req_o rises the cycle after the triggering rx_strobe_i.
  - It falls on the cycle after bus_ack_i, or after ACK_TIMEOUT cycles without ack (then tmo is set).
  - An ack in the timeout-expiry cycle counts as success.
  - Read data is captured into a 16-bit holding register and the rd_valid bit is set.
- tx_byte_o selection:
  - Read in RD_PAD or RD_HI with rd_valid = 1: tx_byte_o = hold[15:8]. In RD_HI on tx_strobe_i, switch to hold[7:0].
  - Read with rd_valid = 0 when tx_strobe_i ends the pad byte: send 8'hFF for both data bytes and set tmo.
  - All other states: status byte.
  - tx_byte_o must be stable on every cycle tx_strobe_i may be high.
- Chip-select deassert (synced cs = 1):
  - Forces IDLE next cycle and clears rd_valid. Sticky flags are kept.
  - An outstanding bus request stays high until ack or timeout; its read data is discarded.
  - If a new command arrives while a stale request is pending, the new request waits (queued by state) until bus_req_o falls.
- rx_strobe_i and tx_strobe_i in the same cycle: process rx first. tx uses the pre-update state's selection.
- No arithmetic beyond the REG_W-bit reg increment and a clog2(ACK_TIMEOUT+1)-bit counter.

Decomposition:
- Package spi_bus_pkg: state enum (IDLE, WR_HI, WR_LO, RD_PAD, RD_HI, RD_LO), command bit-position constants, status bit positions.
- One sub-module is natural: spi_bus_req. It owns the req/ack/timeout handshake and the read-data holding register. The top keeps the protocol FSM and tx mux.

Test Plan:
1. Write, no burst. Command 8'h03, then 8'h12, 8'h34 -> one request: bus_wr_o=1, bus_reg_o=3, bus_data_o=16'h1234. bus_req_o falls the cycle after ack. State returns to IDLE.
2. Read, no burst. Command 8'h85; bus acks after 5 cycles with 16'hBEEF -> host receives pad=status 8'hA2 (req still high when pad loaded), then 8'hBE, 8'hEF.
3. Burst write. Command 8'h4F, then 4 data bytes -> writes go to reg 15 then reg 0 (wrap) with the correct words. With ack withheld on the first write -> second word dropped and ovr set; status reads 8'hA8 (req released after ack).
4. Timeout. Read command 8'h81 with no ack -> bus_req_o drops after exactly 64 cycles. Host receives 8'hFF, 8'hFF. Status has tmo=1. Command 8'h20 clears it -> status 8'hA0.
5. Abort. Deassert CS after the high byte of a write -> no bus request. The next command frame decodes normally as a command.
6. Reset mid-read while bus_req_o=1 -> next cycle bus_req_o=0, tx_byte_o=8'hA0, state IDLE.
